mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Iterative multiply/divide unit with the architectural HI/LO registers, in the EX stage directly downstream of the register file. It consumes the rs/rt read data for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results land in HI/LO, which feed MFHI/MFLO. While an operation is running, `busy` drives the pipeline hazard unit to stall dependent instructions.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
clock  in  1  rising-edge clock for all state
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request; sampled at a rising edge only when busy=0
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
rs_data  in  WIDTH  operand A (multiplicand/dividend/MTxx source), from regfile rdata1
rt_data  in  WIDTH  operand B (multiplier/divisor), from regfile rdata2
busy  out  1  high while MUL/DIV iterations are in progress
done  out  1  one-cycle pulse after HI/LO are updated by MUL/DIV
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared. This applies at any time, including mid-operation, and the in-flight operation is discarded.
- FSM states:
  - IDLE: accepts start.
  - MUL: 32 shift-add iterations.
  - DIV: 32 restoring-division iterations.
  - Final iteration of MUL/DIV returns to IDLE.
- Accept at edge N (start=1, busy=0, IDLE):
  - MULT/MULTU/DIV/DIVU: latch operands. For signed ops, convert to magnitudes and record the result signs. Enter MUL/DIV; busy=1 after edge N; counter=0.
  - MTHI: hi<=rs_data at edge N, lo unchanged. MTLO: lo<=rt... no: lo<=rs_data at edge N, hi unchanged. busy and done stay 0 for both.
  - op 11x: no effect.
- Iterations run on edges N+1..N+32, one bit per edge.
  - At edge N+32: hi/lo are written with the sign-corrected result, busy<=0, done<=1.
  - At edge N+33: done<=0 (unless a new op completes).
  - busy is high for exactly 32 cycles; a new start is accepted at edge N+33 at the earliest.
- hi/lo hold their old values throughout MUL/DIV; they only update at completion.
- start while busy=1: ignored entirely; operands and op are not re-latched.
- MULT/MULTU: {hi,lo} = 64-bit product (signed/unsigned).
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
- Division by zero: completes in the normal 32 cycles with lo=all ones and hi=rs_data. This holds for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap, no flag.
- Iteration counter is $clog2(WIDTH)+1 bits and must not wrap; the terminal count is WIDTH-1.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF:
  - busy high for 32 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001, done=1 for exactly one cycle.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 after 32 cycles.
- DIV and DIVU:
  - DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIVU 7/2 -> lo=3, hi=1.
- Corner cases:
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Idle and busy handling:
  - MTHI 0x1234 while idle -> hi=0x1234 next edge, lo unchanged, busy/done stay 0.
  - MULT issued, then start+MTLO pulsed at cycle 5 while busy -> lo unaffected by the MTLO; the MULT result is correct.
- Reset mid-operation: assert reset during cycle 10 of a DIVU.
  - busy, done, hi, lo go to 0 immediately (asynchronous).
  - After release, DIVU 9/4 -> lo=2, hi=1 after 32 cycles.

Source files
------------

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide on magnitudes.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div_zero;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [2*WIDTH-1:0] w_prod_fin;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_next;
  logic [WIDTH-1:0]   w_rem_fin;
  logic [WIDTH-1:0]   w_quo_fin;
  logic               w_last;

  // op[0]=0 selects the signed flavour of both MULT and DIV
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & rs_data[WIDTH-1];
  assign w_b_neg  = w_signed & rt_data[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -rs_data : rs_data;
  assign w_b_mag  = w_b_neg ? -rt_data : rt_data;

  assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_prod_fin  = r_neg_res ? -w_prod_next : w_prod_next;

  assign w_shift    = {r_rem, r_q[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], w_fits};
  // Divide by zero yields all-ones quotient; remainder already equals the dividend
  assign w_quo_fin  = r_div_zero ? '1 : (r_neg_res ? -w_q_next : w_q_next);
  assign w_rem_fin  = r_neg_rem ? -w_rem_next : w_rem_next;

  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                r_a       <= w_a_mag;
                r_prod    <= {{WIDTH{1'b0}}, w_b_mag};
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_count   <= '0;
                r_busy    <= 1'b1;
                r_state   <= S_MUL;
              end
              3'b010, 3'b011: begin
                r_b        <= w_b_mag;
                r_q        <= w_a_mag;
                r_rem      <= '0;
                r_neg_res  <= w_a_neg ^ w_b_neg;
                r_neg_rem  <= w_a_neg;
                r_div_zero <= (rt_data == '0);
                r_count    <= '0;
                r_busy     <= 1'b1;
                r_state    <= S_DIV;
              end
              3'b100:  r_hi <= rs_data;
              3'b101:  r_lo <= rs_data;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_prod <= w_prod_next;
          if (w_last) begin
            {r_hi, r_lo} <= w_prod_fin;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          if (w_last) begin
            r_hi    <= w_rem_fin;
            r_lo    <= w_quo_fin;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: table of MUL/DIV vectors through a scoreboard
// queue, plus hand sequences for MTHI/MTLO, start-while-busy and mid-op reset.
module tb_mdu_hilo;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mdu_hilo #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  vec_t        vecs[11];
  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Count remaining busy cycles, then check the done pulse and scoreboard result.
  task automatic finish_op(input string name, input int already);
    int          cyc;
    logic [63:0] exp;
    cyc = already;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clock);
    end
    chk({name, " busy_cycles"}, 64'(cyc), 64'd32);
    chk({name, " done_pulse"}, 64'(done), 64'd1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 64'hx;
    chk({name, " hi"}, 64'(hi), 64'(exp[63:32]));
    chk({name, " lo"}, 64'(lo), 64'(exp[31:0]));
    $display("txn %s: hi=%h lo=%h busy_cycles=%0d", name, hi, lo, cyc);
    @(negedge clock);
    chk({name, " done_clear"}, 64'(done), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_q.push_back({eh, el});
    issue(o, a, b);
    finish_op(name, 0);
  endtask

  initial begin
    vecs[0]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{"div_neg7_2",  OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7_2",    OP_DIVU, 32'd7,        32'd2,        32'd1,        32'd3};
    vecs[4]  = '{"divu_5_0",    OP_DIVU, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5]  = '{"div_min_m1",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6]  = '{"mult_7xneg2", OP_MULT, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[7]  = '{"div_7_neg2",  OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{"div_neg7_0",  OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{"multu_2p16",  OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,       32'd0};
    vecs[10] = '{"divu_100_7",  OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14};

    repeat (2) @(negedge clock);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTLO then MTHI while idle: single-edge writes, no busy/done
    issue(OP_MTLO, 32'hAAAA5555, 32'h0);
    chk("mtlo lo", 64'(lo), 64'h00000000AAAA5555);
    chk("mtlo hi_kept", 64'(hi), 64'd2);
    issue(OP_MTHI, 32'h00001234, 32'h0);
    chk("mthi hi", 64'(hi), 64'h0000000000001234);
    chk("mthi lo_kept", 64'(lo), 64'h00000000AAAA5555);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    $display("txn mthi/mtlo: hi=%h lo=%h", hi, lo);

    // MULT with a MTLO pulsed at cycle 5 of the operation; it must be ignored
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    repeat (4) @(negedge clock);
    start   = 1'b1;
    op      = OP_MTLO;
    rs_data = 32'hDEADBEEF;
    rt_data = 32'h00000007;
    @(negedge clock);
    start = 1'b0;
    chk("busy_start lo_kept", 64'(lo), 64'h00000000AAAA5555);
    chk("busy_start hi_kept", 64'(hi), 64'h0000000000001234);
    finish_op("mult_with_mtlo", 5);

    // Reset during cycle 10 of a DIVU: outputs clear before the next edge
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    $display("txn reset_mid_divu: busy=%b hi=%h lo=%h", busy, hi, lo);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    run_op("divu_9_4_after_reset", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
